// File: rtl/risc_pkg.sv
// Shared types and encodings for the Simple RISC Machine sequencer.
package risc_pkg;

    // Sequencer states, one micro-step per clock.
    typedef enum logic [2:0] {
        WAIT,
        DECODE,
        WRITE_IMM,
        GET_A,
        GET_B,
        ALU,
        WRITE_REG
    } state_t;

    // Instruction classes after opcode/op decode.
    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_MOV_IMM,
        CLS_MOV_REG,
        CLS_ADD,
        CLS_CMP,
        CLS_AND,
        CLS_MVN
    } insn_class_t;

    // Opcode field IR[15:13].
    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    // Op field IR[12:11], interpreted per opcode.
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    // ALU operation encodings driven on alu_op.
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    // Map an opcode/op pair onto its instruction class.
    function automatic insn_class_t classify(input logic [2:0] opcode, input logic [1:0] op);
        insn_class_t cls;
        cls = CLS_ILLEGAL;
        if (opcode == OPC_MOV) begin
            if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
            else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
        end else if (opcode == OPC_ALU) begin
            case (op)
                OP_ADD:  cls = CLS_ADD;
                OP_CMP:  cls = CLS_CMP;
                OP_AND:  cls = CLS_AND;
                default: cls = CLS_MVN;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/insn_decoder.sv
// Combinational instruction decode: field extraction, class/legality, sximm8.
import risc_pkg::*;

module insn_decoder #(
    parameter int data_width = 16
) (
    input  logic [15:0]           i_ir,
    output logic [2:0]            o_rn,
    output logic [2:0]            o_rd,
    output logic [2:0]            o_rm,
    output logic [1:0]            o_sh,
    output insn_class_t           o_cls,
    output logic                  o_legal,
    output logic [data_width-1:0] o_sximm8
);

    assign o_rn     = i_ir[10:8];
    assign o_rd     = i_ir[7:5];
    assign o_sh     = i_ir[4:3];
    assign o_rm     = i_ir[2:0];
    assign o_cls    = classify(i_ir[15:13], i_ir[12:11]);
    assign o_legal  = (o_cls != CLS_ILLEGAL);
    assign o_sximm8 = {{(data_width-8){i_ir[7]}}, i_ir[7:0]};

endmodule

// File: rtl/regfile_ctrl_fsm.sv
// Instruction sequencer: latches one instruction and steps the regfile/datapath
// through it one micro-step per clock. Moore outputs from state + IR only.
import risc_pkg::*;

module regfile_ctrl_fsm #(
    parameter int data_width = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  s,
    input  logic [15:0]           in,
    output logic                  w,
    output logic                  err,
    output logic [2:0]            writenum,
    output logic                  write,
    output logic [2:0]            readnum,
    output logic                  vsel,
    output logic                  loada,
    output logic                  loadb,
    output logic                  loadc,
    output logic                  loads,
    output logic                  asel,
    output logic [1:0]            shift,
    output logic [1:0]            alu_op,
    output logic [data_width-1:0] sximm8
);

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_ir;

    logic [2:0]  w_rn;
    logic [2:0]  w_rd;
    logic [2:0]  w_rm;
    logic [1:0]  w_sh;
    insn_class_t w_cls;
    logic        w_legal;

    insn_decoder #(
        .data_width(data_width)
    ) u_dec (
        .i_ir     (r_ir),
        .o_rn     (w_rn),
        .o_rd     (w_rd),
        .o_rm     (w_rm),
        .o_sh     (w_sh),
        .o_cls    (w_cls),
        .o_legal  (w_legal),
        .o_sximm8 (sximm8)
    );

    // State register; reset drops straight back to WAIT, abandoning any write.
    // NOTE: registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= WAIT;
        else       r_state <= w_next_state;
    end

    // Instruction register: captured only on a start in WAIT, held otherwise.
    // NOTE: IR is a single control register, so it is reset; it is not a memory array.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                    r_ir <= '0;
        else if (r_state == WAIT && s) r_ir <= in;
    end

    // Next-state selection from current state and decoded instruction class.
    // NOTE: assigning a default first keeps every path driven and avoids latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            WAIT:      if (s) w_next_state = DECODE;
            DECODE: begin
                case (w_cls)
                    CLS_MOV_IMM:                   w_next_state = WRITE_IMM;
                    CLS_MOV_REG, CLS_MVN:          w_next_state = GET_B;
                    CLS_ADD, CLS_CMP, CLS_AND:     w_next_state = GET_A;
                    default:                       w_next_state = WAIT;
                endcase
            end
            WRITE_IMM: w_next_state = WAIT;
            GET_A:     w_next_state = GET_B;
            GET_B:     w_next_state = ALU;
            ALU:       w_next_state = (w_cls == CLS_CMP) ? WAIT : WRITE_REG;
            WRITE_REG: w_next_state = WAIT;
            default:   w_next_state = WAIT;
        endcase
    end

    // Moore output decode; every strobe is idle unless its state asserts it.
    always_comb begin
        w        = 1'b0;
        err      = 1'b0;
        writenum = 3'd0;
        write    = 1'b0;
        readnum  = 3'd0;
        vsel     = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        shift    = 2'b00;
        alu_op   = ALU_ADD;
        case (r_state)
            WAIT:   w   = 1'b1;
            DECODE: err = ~w_legal;
            WRITE_IMM: begin
                write    = 1'b1;
                writenum = w_rn;
                vsel     = 1'b1;
            end
            GET_A: begin
                readnum = w_rn;
                loada   = 1'b1;
            end
            GET_B: begin
                readnum = w_rm;
                loadb   = 1'b1;
            end
            ALU: begin
                readnum = w_rm;
                shift   = w_sh;
                asel    = (w_cls == CLS_MOV_REG) || (w_cls == CLS_MVN);
                case (w_cls)
                    CLS_CMP: alu_op = ALU_SUB;
                    CLS_AND: alu_op = ALU_AND;
                    CLS_MVN: alu_op = ALU_NOTB;
                    default: alu_op = ALU_ADD;
                endcase
                if (w_cls == CLS_CMP) loads = 1'b1;
                else                  loadc = 1'b1;
            end
            WRITE_REG: begin
                write    = 1'b1;
                writenum = w_rd;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_regfile_ctrl_fsm.sv
// Self-checking bench: directed cases plus randomized instruction streams
// compared cycle by cycle against a per-instruction micro-step model.
module tb_regfile_ctrl_fsm;

    logic        clk = 1'b0;
    logic        reset;
    logic        s;
    logic [15:0] in;
    logic        w, err, write, vsel, loada, loadb, loadc, loads, asel;
    logic [2:0]  writenum, readnum;
    logic [1:0]  shift, alu_op;
    logic [15:0] sximm8;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] ir_model;       // what the IR should hold
    logic [34:0] exp_q[$];       // expected busy-cycle vectors for one instruction

    regfile_ctrl_fsm #(.data_width(16)) dut (
        .clk(clk), .reset(reset), .s(s), .in(in),
        .w(w), .err(err), .writenum(writenum), .write(write), .readnum(readnum),
        .vsel(vsel), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .shift(shift), .alu_op(alu_op), .sximm8(sximm8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] pack(
        input logic w_, input logic err_, input logic [2:0] wn, input logic wr,
        input logic [2:0] rn, input logic vs, input logic la, input logic lb,
        input logic lc, input logic ls, input logic as, input logic [1:0] sh,
        input logic [1:0] aop, input logic [15:0] sx);
        return {w_, err_, wn, wr, rn, vs, la, lb, lc, ls, as, sh, aop, sx};
    endfunction

    function automatic logic [34:0] observed();
        return {w, err, writenum, write, readnum, vsel, loada, loadb, loadc, loads,
                asel, shift, alu_op, sximm8};
    endfunction

    function automatic logic [15:0] sext(input logic [15:0] ir);
        return {{8{ir[7]}}, ir[7:0]};
    endfunction

    function automatic logic [34:0] idle_vec(input logic [15:0] ir);
        return pack(1'b1, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    2'b00, 2'b00, sext(ir));
    endfunction

    // Reference model: list every busy cycle an instruction should produce.
    task automatic build_expect(input logic [15:0] ir);
        logic [4:0]  kind;
        logic        movi, movr, add, cmp, andi, mvn, legal;
        logic [2:0]  rn, rd, rm;
        logic [1:0]  sh, aop;
        logic [15:0] sx;
        kind = ir[15:11];
        movi = (kind == 5'b11010);
        movr = (kind == 5'b11000);
        add  = (kind == 5'b10100);
        cmp  = (kind == 5'b10101);
        andi = (kind == 5'b10110);
        mvn  = (kind == 5'b10111);
        legal = movi | movr | add | cmp | andi | mvn;
        rn = ir[10:8]; rd = ir[7:5]; rm = ir[2:0]; sh = ir[4:3]; sx = sext(ir);
        aop = add ? 2'd0 : cmp ? 2'd1 : andi ? 2'd2 : mvn ? 2'd3 : 2'd0;
        exp_q.delete();
        exp_q.push_back(pack(0, !legal, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, sx));
        if (movi)
            exp_q.push_back(pack(0, 0, rn, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, sx));
        if (add | cmp | andi)
            exp_q.push_back(pack(0, 0, 0, 0, rn, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, sx));
        if (legal && !movi) begin
            exp_q.push_back(pack(0, 0, 0, 0, rm, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, sx));
            exp_q.push_back(pack(0, 0, 0, 0, rm, 0, 0, 0, !cmp, cmp, movr | mvn, sh, aop, sx));
            if (!cmp)
                exp_q.push_back(pack(0, 0, rd, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, sx));
        end
    endtask

    // Enter at a negedge with the DUT idle; leave at the negedge where it is idle again.
    task automatic run_insn(input string name, input logic [15:0] insn, input logic hold_s);
        check({name, "_wait"}, observed(), idle_vec(ir_model));
        s  = 1'b1;
        in = insn;
        build_expect(insn);
        ir_model = insn;
        @(posedge clk);
        foreach (exp_q[i]) begin
            @(negedge clk);
            check($sformatf("%s_step%0d", name, i), observed(), exp_q[i]);
            s  = hold_s ? 1'b1 : 1'($urandom_range(0, 1));
            in = 16'($urandom);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            check("idle", observed(), idle_vec(ir_model));
            s  = 1'b0;
            in = 16'($urandom);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [4:0] legal_kinds [6];
        logic [15:0] insn;
        legal_kinds[0] = 5'b11010; legal_kinds[1] = 5'b11000; legal_kinds[2] = 5'b10100;
        legal_kinds[3] = 5'b10101; legal_kinds[4] = 5'b10110; legal_kinds[5] = 5'b10111;

        reset = 1'b1; s = 1'b0; in = 16'h0000; ir_model = 16'h0000;
        repeat (2) @(negedge clk);
        check("reset_state", observed(), idle_vec(16'h0000));
        reset = 1'b0;
        @(negedge clk);

        // Async reset while DECODE shows err for an illegal instruction.
        s = 1'b1; in = 16'hE0FF;
        @(posedge clk); #1;
        check("decode_err", observed(), pack(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'hFFFF));
        reset = 1'b1; #1;
        check("reset_in_decode", observed(), idle_vec(16'h0000));
        @(negedge clk);
        reset = 1'b0; s = 1'b0; ir_model = 16'h0000;
        @(negedge clk);
        check("ir_after_reset", observed(), idle_vec(16'h0000));

        // Async reset during the write cycle of MOV-imm: write drops at once.
        s = 1'b1; in = 16'hD3FB;
        @(posedge clk); @(posedge clk); #1;
        check("write_imm_pre_reset", observed(), pack(0, 0, 3'd3, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 16'hFFFB));
        reset = 1'b1; #1;
        check("reset_in_write", observed(), idle_vec(16'h0000));
        @(negedge clk);
        reset = 1'b0; s = 1'b0; ir_model = 16'h0000;
        @(negedge clk);

        // Directed instructions.
        run_insn("mov_imm", 16'hD3FB, 1'b0);
        idle(2);
        run_insn("add", 16'hA140, 1'b0);
        run_insn("cmp", 16'hAD06, 1'b0);
        run_insn("mov_reg", 16'hC0E9, 1'b0);
        run_insn("illegal", 16'h0000, 1'b1);
        run_insn("add_held_s", 16'hA140, 1'b1);
        idle(1);

        // Randomized stream, mostly legal, with random gaps and held starts.
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0)
                insn = 16'($urandom);
            else
                insn = {legal_kinds[$urandom_range(0, 5)], 11'($urandom)};
            run_insn("rand", insn, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
